debug_capture: RTL and testbench
================================

Name: debug_capture

Overview:
- Producer side of the on-screen hex debug overlay: captures timestamped event words and presents them as eight 64-bit rows on o_debug0..o_debug7, which feed the overlay's debug row inputs directly.
- Holds an 8-deep newest-first history with an arm/trigger/post-trigger state machine.
- Updates its outputs only on the rising edge of vblank, so the overlay never shows a torn frame.

Parameters:
- POST_COUNT, 4: number of events accepted after the trigger event before capture stops; range 0..7.

Ports:
- clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_strobe  in  1  event-valid pulse; one event per cycle high
- i_data  in  48  event payload
- i_trig_mask  in  48  trigger compare mask
- i_trig_value  in  48  trigger compare value
- i_arm  in  1  arm request pulse
- i_freeze  in  1  hold the o_debug outputs
- i_vblank  in  1  vertical blank from the video timing
- o_debug0..o_debug7  out  64 each  history rows; row 0 is the newest
- o_state  out  2  0=RUN, 1=ARMED, 2=POST, 3=STOPPED
- o_drop  out  8  saturating count of strobes ignored while STOPPED

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - timestamp counter = 0
  - history h[0..7] = 0
  - o_debug* = 0
  - state = RUN; post counter = 0; o_drop = 0
  - vblank_q = 1, which suppresses a spurious copy on release.
- Timestamp ts: 16-bit free-running counter, increments every clk and wraps FFFF->0000.
- Event word = {ts[15:0], i_data[47:0]}. ts is the counter value in the strobe cycle.
- Accepted strobe: h[0] <= word and h[i] <= h[i-1] for i=1..7; h[7] is discarded. h updates on the clock edge ending the strobe cycle.
- Trigger match: (i_data & i_trig_mask) == (i_trig_value & i_trig_mask). A mask of 0 always matches.
- State machine (o_state is the registered state):
  - RUN: every strobe is accepted and no trigger is evaluated. i_arm -> ARMED. If i_arm and i_strobe are both high, the strobe is accepted as a RUN strobe.
  - ARMED: every strobe is accepted. A strobe with a match loads the post counter with POST_COUNT, then goes to POST if POST_COUNT>0, else to STOPPED. i_arm is ignored.
  - POST: every strobe is accepted and decrements the post counter. The strobe taken at counter==1 -> STOPPED. i_arm is ignored. Trigger matches in this state are irrelevant.
  - STOPPED: strobes are not accepted and h is frozen. Each ignored strobe increments o_drop, which saturates at FF. i_arm -> ARMED; h is kept and o_drop is not cleared.
- Display update:
  - vblank_q <= i_vblank every cycle.
  - Rising edge = i_vblank & ~vblank_q.
  - On a rising edge with i_freeze=0: o_debugN <= h[N] for all N, in one cycle.
  - With i_freeze=1 the outputs hold, and a rising edge during freeze is lost. There is no deferred update.
- Simultaneous strobe and vblank edge: the copy takes h as it was before that strobe. The strobe appears at the next edge.
- Latency:
  - Strobe in cycle n: h valid at n+1.
  - The value reaches o_debug at the first vblank rising edge detected at cycle >= n+1, plus 1 cycle.
- Reset asserted mid-POST: everything clears immediately; state = RUN.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then 3 strobes with i_data=0x000000000001/2/3 at ts 10, 11, 12, then a vblank rise:
  - o_debug0=0x000C000000000003, o_debug1=0x000B000000000002, o_debug2=0x000A000000000001, rows 3..7 = 0.
  - o_debug* stay 0 until the vblank edge.
- 10 consecutive strobes with data 1..10, then vblank:
  - o_debug0 data=10 ... o_debug7 data=3; data 1 and 2 are discarded.
- POST_COUNT=4, arm, mask=0x0000000000FF, value=0x000000000055, strobes with data 0x11, 0x55, 1, 2, 3, 4, 5, 6:
  - State sequence is RUN->ARMED->POST->STOPPED after data 4.
  - After vblank, o_debug0 data=4 and o_debug4 data=0x55.
  - o_drop=2.
- i_freeze=1 across 2 vblank edges with new strobes in between:
  - o_debug unchanged.
  - Drop freeze; the next edge shows the latest history.
- Strobe and vblank rise in the same cycle:
  - The copy excludes that strobe; the following vblank edge includes it in o_debug0.
- POST_COUNT=0 and a match: ARMED->STOPPED directly; reset asserted mid-POST -> all outputs 0 and o_state=0 asynchronously.

Source files
------------

// File: rtl/debug_capture.sv
// Captures timestamped events into an 8-deep newest-first history and mirrors it to eight overlay rows on vblank rise.
// Latency: a strobe lands in history on the next edge and appears on o_debug one cycle after the next vblank rise.
// Backpressure: none; strobes arriving while STOPPED are counted in o_drop (saturating) and discarded.
`timescale 1ns/1ps
module debug_capture #(
    parameter int unsigned POST_COUNT = 4
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_strobe,
    input  logic [47:0] i_data,
    input  logic [47:0] i_trig_mask,
    input  logic [47:0] i_trig_value,
    input  logic        i_arm,
    input  logic        i_freeze,
    input  logic        i_vblank,
    output logic [63:0] o_debug0,
    output logic [63:0] o_debug1,
    output logic [63:0] o_debug2,
    output logic [63:0] o_debug3,
    output logic [63:0] o_debug4,
    output logic [63:0] o_debug5,
    output logic [63:0] o_debug6,
    output logic [63:0] o_debug7,
    output logic [1:0]  o_state,
    output logic [7:0]  o_drop
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ARMED   = 2'd1,
        ST_POST    = 2'd2,
        ST_STOPPED = 2'd3
    } state_t;

    typedef struct packed {
        logic [15:0] ts;
        logic [47:0] dat;
    } evt_t;

    localparam logic [2:0] POST_LD = 3'(POST_COUNT);

    state_t          state, state_nxt;
    logic [2:0]      post_cnt, post_cnt_nxt;
    logic [15:0]     ts;
    evt_t [7:0]      hist;
    evt_t [7:0]      disp;
    evt_t            word;
    logic            vblank_q;
    logic            vblank_rise;
    logic            trig_hit;
    logic            accept;
    logic [7:0]      drop;

    assign word        = '{ts: ts, dat: i_data};
    assign trig_hit    = ((i_data & i_trig_mask) == (i_trig_value & i_trig_mask));
    assign accept      = i_strobe && (state != ST_STOPPED);
    assign vblank_rise = i_vblank && !vblank_q;

    always_comb begin
        state_nxt    = state;
        post_cnt_nxt = post_cnt;
        case (state)
            ST_RUN: begin
                if (i_arm) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (i_strobe && trig_hit) begin
                    post_cnt_nxt = POST_LD;
                    state_nxt    = (POST_LD != 3'd0) ? ST_POST : ST_STOPPED;
                end
            end
            ST_POST: begin
                if (i_strobe) begin
                    post_cnt_nxt = post_cnt - 3'd1;
                    // <=1 rather than ==1 so a corrupted zero count cannot wrap and stall in POST
                    if (post_cnt <= 3'd1) state_nxt = ST_STOPPED;
                end
            end
            ST_STOPPED: begin
                if (i_arm) state_nxt = ST_ARMED;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= ST_RUN;
            post_cnt <= 3'd0;
            ts       <= 16'd0;
            hist     <= '0;
            drop     <= 8'd0;
        end else begin
            state    <= state_nxt;
            post_cnt <= post_cnt_nxt;
            ts       <= ts + 16'd1;
            if (accept) hist <= {hist[6:0], word};
            if (i_strobe && (state == ST_STOPPED) && (drop != 8'hFF)) drop <= drop + 8'd1;
        end
    end

    // vblank_q resets high so a vblank already high at release is not seen as a rise
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            vblank_q <= 1'b1;
            disp     <= '0;
        end else begin
            vblank_q <= i_vblank;
            if (vblank_rise && !i_freeze) disp <= hist;
        end
    end

    assign o_debug0 = disp[0];
    assign o_debug1 = disp[1];
    assign o_debug2 = disp[2];
    assign o_debug3 = disp[3];
    assign o_debug4 = disp[4];
    assign o_debug5 = disp[5];
    assign o_debug6 = disp[6];
    assign o_debug7 = disp[7];
    assign o_state  = state;
    assign o_drop   = drop;

endmodule

// File: tb/tb_debug_capture.sv
// Directed bench for debug_capture: history shift, trigger/post FSM, freeze and vblank timing, async reset.
`timescale 1ns/1ps
module tb_debug_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_reset, i_strobe, i_arm, i_freeze, i_vblank;
    logic [47:0] i_data, i_trig_mask, i_trig_value;
    logic [7:0][63:0] dbg, zdbg;
    logic [1:0]  st, zst;
    logic [7:0]  drp, zdrp;

    int tests = 0;
    int fails = 0;

    // Reference timestamp: value the DUT counter holds during the current cycle
    logic [15:0] tb_ts;
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) tb_ts <= 16'd0;
        else         tb_ts <= tb_ts + 16'd1;
    end

    debug_capture #(.POST_COUNT(4)) dut (
        .clk(clk), .i_reset(i_reset), .i_strobe(i_strobe), .i_data(i_data),
        .i_trig_mask(i_trig_mask), .i_trig_value(i_trig_value), .i_arm(i_arm),
        .i_freeze(i_freeze), .i_vblank(i_vblank),
        .o_debug0(dbg[0]), .o_debug1(dbg[1]), .o_debug2(dbg[2]), .o_debug3(dbg[3]),
        .o_debug4(dbg[4]), .o_debug5(dbg[5]), .o_debug6(dbg[6]), .o_debug7(dbg[7]),
        .o_state(st), .o_drop(drp)
    );

    debug_capture #(.POST_COUNT(0)) dut0 (
        .clk(clk), .i_reset(i_reset), .i_strobe(i_strobe), .i_data(i_data),
        .i_trig_mask(i_trig_mask), .i_trig_value(i_trig_value), .i_arm(i_arm),
        .i_freeze(i_freeze), .i_vblank(i_vblank),
        .o_debug0(zdbg[0]), .o_debug1(zdbg[1]), .o_debug2(zdbg[2]), .o_debug3(zdbg[3]),
        .o_debug4(zdbg[4]), .o_debug5(zdbg[5]), .o_debug6(zdbg[6]), .o_debug7(zdbg[7]),
        .o_state(zst), .o_drop(zdrp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic vpulse();
        i_vblank = 1'b1;
        step();
        i_vblank = 1'b0;
        step();
    endtask

    task automatic strobe(input logic [47:0] dv, output logic [15:0] tsv);
        i_strobe = 1'b1;
        i_data   = dv;
        tsv      = tb_ts;
        step();
        i_strobe = 1'b0;
    endtask

    logic [15:0] t2 [10];
    logic [15:0] t11, t55, t4, tx, ta1, ta2, tb1;

    initial begin
        i_reset = 1'b1; i_strobe = 1'b0; i_arm = 1'b0; i_freeze = 1'b0; i_vblank = 1'b0;
        i_data = '0; i_trig_mask = '0; i_trig_value = '0;
        step(); step();
        check("rst_dbg0", dbg[0], 64'd0);
        check("rst_dbg7", dbg[7], 64'd0);
        check("rst_state", 64'(st), 64'd0);
        check("rst_drop", 64'(drp), 64'd0);
        i_reset = 1'b0;

        // ts 10,11,12 strobes, hand-computed words
        repeat (10) step();
        strobe(48'h1, tx);
        strobe(48'h2, tx);
        strobe(48'h3, tx);
        step();
        check("pre_vblank_dbg0", dbg[0], 64'd0);
        vpulse();
        check("t1_dbg0", dbg[0], 64'h000C_0000_0000_0003);
        check("t1_dbg1", dbg[1], 64'h000B_0000_0000_0002);
        check("t1_dbg2", dbg[2], 64'h000A_0000_0000_0001);
        check("t1_dbg3", dbg[3], 64'd0);
        check("t1_dbg7", dbg[7], 64'd0);

        // 10 back-to-back strobes; rows keep data 10..3, mask 0 in RUN must not trigger
        for (int k = 0; k < 10; k++) strobe(48'(k + 1), t2[k]);
        vpulse();
        for (int n = 0; n < 8; n++)
            check($sformatf("t2_dbg%0d", n), dbg[n], {t2[9 - n], 48'(10 - n)});
        check("t2_state_run", 64'(st), 64'd0);

        // arm / trigger / post
        i_trig_mask = 48'hFF; i_trig_value = 48'h55;
        i_arm = 1'b1; step(); i_arm = 1'b0;
        check("t3_armed", 64'(st), 64'd1);
        strobe(48'h11, t11);
        check("t3_nomatch_armed", 64'(st), 64'd1);
        strobe(48'h55, t55);
        check("t3_post", 64'(st), 64'd2);
        check("t3_pc0_stopped", 64'(zst), 64'd3);
        strobe(48'h1, tx);
        strobe(48'h2, tx);
        strobe(48'h3, tx);
        check("t3_still_post", 64'(st), 64'd2);
        strobe(48'h4, t4);
        check("t3_stopped", 64'(st), 64'd3);
        strobe(48'h5, tx);
        strobe(48'h6, tx);
        check("t3_drop", 64'(drp), 64'd2);
        check("t3_pc0_drop", 64'(zdrp), 64'd6);
        vpulse();
        check("t3_dbg0", dbg[0], {t4, 48'h4});
        check("t3_dbg4", dbg[4], {t55, 48'h55});
        check("t3_pc0_dbg0", zdbg[0], {t55, 48'h55});
        check("t3_pc0_dbg1", zdbg[1], {t11, 48'h11});

        // freeze across two vblank edges
        i_arm = 1'b1; step(); i_arm = 1'b0;
        check("t4_rearm", 64'(st), 64'd1);
        check("t4_drop_kept", 64'(drp), 64'd2);
        i_freeze = 1'b1;
        strobe(48'hA1, ta1);
        vpulse();
        strobe(48'hA2, ta2);
        vpulse();
        check("t4_frozen_dbg0", dbg[0], {t4, 48'h4});
        check("t4_frozen_dbg4", dbg[4], {t55, 48'h55});
        i_freeze = 1'b0;
        step();
        check("t4_no_deferred", dbg[0], {t4, 48'h4});
        vpulse();
        check("t4_dbg0", dbg[0], {ta2, 48'hA2});
        check("t4_dbg1", dbg[1], {ta1, 48'hA1});
        check("t4_dbg2", dbg[2], {t4, 48'h4});

        // strobe coincident with vblank rise
        i_strobe = 1'b1; i_data = 48'hB1; tb1 = tb_ts; i_vblank = 1'b1;
        step();
        i_strobe = 1'b0; i_vblank = 1'b0;
        step();
        check("t5_excl_dbg0", dbg[0], {ta2, 48'hA2});
        vpulse();
        check("t5_incl_dbg0", dbg[0], {tb1, 48'hB1});
        check("t5_incl_dbg1", dbg[1], {ta2, 48'hA2});

        // async reset in POST
        strobe(48'h55, tx);
        check("t6_post", 64'(st), 64'd2);
        check("t6_pc0_stopped", 64'(zst), 64'd3);
        check("t6_dbg7_pre", dbg[7], {t55, 48'h55});
        i_reset = 1'b1;
        #1;
        check("t6_rst_dbg0", dbg[0], 64'd0);
        check("t6_rst_dbg7", dbg[7], 64'd0);
        check("t6_rst_state", 64'(st), 64'd0);
        check("t6_rst_drop", 64'(drp), 64'd0);
        check("t6_rst_pc0_state", 64'(zst), 64'd0);
        check("t6_rst_pc0_drop", 64'(zdrp), 64'd0);
        step();
        i_reset = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
